// File: rtl/ti_sbox_share_driver.sv
// Host-side driver for the TI S-box byte-serial protocol: masks a byte into
// Boolean shares, streams shares + refresh bytes, then XOR-recombines the output shares.
module ti_sbox_share_driver #(
   parameter int NUM_SHARES = 3,
   parameter int NUM_EXTRA  = 2,
   parameter int TIMEOUT    = 64
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic [7:0]                              data_in,
   input  logic [8*(NUM_SHARES-1+NUM_EXTRA)-1:0]   rnd_in,
   output logic                                    ready,
   output logic                                    sh_load,
   output logic [7:0]                              sh_out,
   input  logic                                    sbox_ready,
   input  logic [7:0]                              sbox_out,
   output logic                                    res_valid,
   output logic [7:0]                              result,
   output logic                                    err
);

   localparam int L  = NUM_SHARES + NUM_EXTRA;
   localparam int RW = 8 * (L - 1);
   localparam int IW = $clog2(L);
   localparam int CW = $clog2(NUM_SHARES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [IW-1:0] IDX_LAST = IW'(L - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SHARES - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEND    = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_COLLECT = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]    state;
   logic [IW-1:0] idx;
   logic [CW-1:0] cnt;
   logic [TW-1:0] wcnt;
   logic [RW-1:0] rnd_q;
   logic [7:0]    acc;
   logic [7:0]    share0;

   // Share 0 is built straight from the inputs so the unmasked byte is never stored.
   always_comb begin
      share0 = data_in;
      for (int k = 0; k < NUM_SHARES - 1; k++)
         share0 = share0 ^ rnd_in[8*k +: 8];
   end

   assign ready = (state == S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         cnt       <= '0;
         wcnt      <= '0;
         rnd_q     <= '0;
         acc       <= '0;
         sh_load   <= 1'b0;
         sh_out    <= 8'h00;
         res_valid <= 1'b0;
         result    <= 8'h00;
         err       <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         err       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  rnd_q   <= rnd_in;
                  idx     <= '0;
                  sh_load <= 1'b1;
                  sh_out  <= share0;
                  state   <= S_SEND;
               end
            end
            S_SEND: begin
               if (idx == IDX_LAST) begin
                  sh_load <= 1'b0;
                  sh_out  <= 8'h00;
                  wcnt    <= '0;
                  state   <= S_WAIT;
               end else begin
                  // Stream byte idx+1 is rnd byte idx: masks first, then refresh values.
                  idx    <= idx + 1'b1;
                  sh_out <= rnd_q[{idx, 3'b000} +: 8];
               end
            end
            S_WAIT: begin
               if (sbox_ready) begin
                  acc   <= sbox_out;
                  cnt   <= CW'(1);
                  state <= S_COLLECT;
               end else if (wcnt == T_LAST) begin
                  err   <= 1'b1;
                  state <= S_DONE;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            S_COLLECT: begin
               if (!sbox_ready) begin
                  err   <= 1'b1;
                  state <= S_DONE;
               end else begin
                  acc <= acc ^ sbox_out;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) begin
                     result    <= acc ^ sbox_out;
                     res_valid <= 1'b1;
                     state     <= S_DONE;
                  end
               end
            end
            // One cycle so ready rises the cycle after res_valid/err.
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ti_sbox_share_driver.md
Name: ti_sbox_share_driver

Overview:
- Host-side driver for the serial load/unload interface of the threshold-implementation (TI) S-box core.
- Splits an unmasked byte into Boolean shares using host-supplied randomness, then streams them with the refresh bytes into the core one per cycle under a load strobe.
- Collects the core's serial output shares and XOR-recombines them into the unmasked result.
- Sits between the unmasked datapath and the TI S-box; it is the transmitter and receiver for the core's byte-serial share protocol.

Parameters:
- NUM_SHARES, 3, number of Boolean shares per byte, both in and out; must be ≥2.
- NUM_EXTRA, 2, number of refresh-randomness bytes streamed after the shares.
- TIMEOUT, 64, maximum cycles in WAIT for the core's out_ready before aborting; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; accepted only when ready=1.
- data_in  input  8  unmasked input byte; sampled on the accepted start.
- rnd_in  input  8*(NUM_SHARES-1+NUM_EXTRA)  randomness; sampled on the accepted start. Byte k is bits [8k+7:8k]. Bytes 0..NUM_SHARES-2 are masks m1.., the remaining bytes are refresh values r1...
- ready  output  1  high in IDLE only.
- sh_load  output  1  load strobe to the core (core in_load).
- sh_out  output  8  share/randomness byte to the core (core in).
- sbox_ready  input  1  core out_ready; one output share per cycle while high.
- sbox_out  input  8  core output share byte.
- res_valid  output  1  one-cycle pulse; result holds the recombined byte.
- result  output  8  unmasked S-box output; holds its value until the next res_valid.
- err  output  1  one-cycle pulse on timeout or an incomplete collect.

Behaviour:
- Reset, asynchronous while rst=0:
  - state=IDLE; ready=1.
  - sh_load=0, sh_out=0x00, res_valid=0, result=0x00, err=0.
  - All counters and captured registers are cleared.
  - A reset mid-operation abandons the operation with no err pulse.
- IDLE:
  - start=1 captures data_in and rnd_in. The next state is SEND with idx=0.
  - ready drops in the cycle after acceptance.
  - start while not in IDLE is ignored. No queueing.
- SEND, lasting L = NUM_SHARES+NUM_EXTRA cycles:
  - sh_load=1 and sh_out is registered.
  - idx=0: sh_out = data ^ m1 ^ … ^ m(NUM_SHARES-1).
  - idx=1..NUM_SHARES-1: sh_out = m(idx).
  - Remaining idx values: sh_out = refresh bytes r1.. in order.
  - After idx=L-1 the next state is WAIT. sh_load=0 and sh_out=0x00 in the following cycle.
  - The first sh_load=1 cycle is the cycle after start is accepted, so latency from start to first share is 1.
- WAIT:
  - Counts cycles. On sbox_ready=1, capture sbox_out into the accumulator (acc=sbox_out), set cnt=1, and go to COLLECT.
  - If TIMEOUT cycles elapse with no sbox_ready, pulse err and return to IDLE.
  - sbox_ready in any state other than WAIT or COLLECT is ignored.
- COLLECT:
  - Each cycle with sbox_ready=1: acc ^= sbox_out and cnt++.
  - When cnt reaches NUM_SHARES: result = acc, res_valid pulses in that same registered cycle, and the next state is IDLE.
  - If sbox_ready drops before all NUM_SHARES shares arrive: pulse err, result unchanged, return to IDLE.
- Throughput:
  - ready returns the cycle after res_valid or err.
  - A start asserted in that cycle is accepted normally.
- All arithmetic is 8-bit XOR only. Masks are never exposed on result; data is never driven unmasked on sh_out.
- err and res_valid are never high in the same cycle.

Test Plan:
- Reset, then start with data_in=0x63 and rnd_in=0x95F80504 (m1=0x04, m2=0x05, r1=0xF8, r2=0x95) -> sh_load high for 5 cycles starting 1 cycle after start; sh_out = 0x62, 0x04, 0x05, 0xF8, 0x95; then sh_load=0 and sh_out=0x00.
- After the stream, drive sbox_ready high for 3 cycles with sbox_out = 0x10, 0x20, 0x33 -> res_valid pulses once, result=0x03, ready=1 on the next cycle.
- After the stream, hold sbox_ready low for 64 cycles -> err pulses once, res_valid stays 0, result keeps its previous value (0x03), state returns to IDLE.
- Drive sbox_ready high for 2 cycles then low -> err pulse, no res_valid; result unchanged.
- Pulse start mid-SEND with different data -> ignored: the stream and result match the first request.
- Assert rst=0 during COLLECT -> all outputs go to reset values immediately, without waiting for a clock; after release ready=1 and a new operation completes correctly.
